// File: rtl/data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_arbiter
//
// Shares one multi-cycle data_ram between two masters (typically the I-cache
// and D-cache refill paths). Requests are arbitrated round-robin in IDLE. The
// winner's we/addr/din are latched onto the RAM port and ram_cs is held until
// ram_ack, after which read data and a one-cycle ack go back to the winner.
// A watchdog aborts a transfer whose ram_ack never arrives and flags err.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   mX_cs/we/addr/din          master X request (cs held until mX_ack)
//   mX_dout                    registered read data, held until next completion
//   mX_ack, mX_err             one-cycle completion pulse, timeout flag
//   mX_stall                   mX_cs & ~mX_ack
//   ram_cs/we/addr/din         registered RAM controls and latched request
//   ram_dout, ram_ack          RAM read data and completion pulse
//   grant                      one-hot owner of the current transfer
//   busy                       high while a transfer is in BUSY or DONE
// -----------------------------------------------------------------------------
module data_ram_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cs,
    input  logic        m1_cs,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_din,
    input  logic [31:0] m1_din,
    output logic [31:0] m0_dout,
    output logic [31:0] m1_dout,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic        m0_stall,
    output logic        m1_stall,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    input  logic [31:0] ram_dout,
    input  logic        ram_ack,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // TIMEOUT is at most 255, so an 8-bit watchdog always suffices.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;

    logic        w_start;      // IDLE accepts a request this cycle
    logic        w_sel;        // winner of this arbitration: 0 = m0, 1 = m1
    logic        w_finish;     // BUSY sees ram_ack
    logic        w_abort;      // BUSY watchdog expired without ram_ack

    logic        r_last;       // 1 = m1 was granted most recently
    logic [7:0]  r_cnt;
    logic [1:0]  r_grant;
    logic [1:0]  r_ack;
    logic [1:0]  r_err;
    logic [31:0] r_m0_dout;
    logic [31:0] r_m1_dout;
    logic        r_ram_cs;
    logic        r_ram_we;
    logic [31:0] r_ram_addr;
    logic [31:0] r_ram_din;

    // NOTE: every sequential block uses non-blocking assignments so that all
    // registers update from the same pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips an assignment infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_sel        = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (m0_cs || m1_cs) begin
                    w_start      = 1'b1;
                    // On a tie the master that did not win last time goes first;
                    // otherwise the single requester wins.
                    w_sel        = (m0_cs && m1_cs) ? ~r_last : m1_cs;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (ram_ack) begin
                    w_finish     = 1'b1;
                    w_next_state = ST_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_abort      = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // Masters are ignored here; ram_cs stays low for this cycle so
                // the RAM returns to idle before the next access.
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last     <= 1'b1;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_err      <= '0;
            r_m0_dout  <= '0;
            r_m1_dout  <= '0;
            r_ram_cs   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
        end else begin
            // ack/err are single-cycle pulses, set only on entry to DONE.
            r_ack <= '0;
            r_err <= '0;

            if (w_start) begin
                r_ram_cs   <= 1'b1;
                r_ram_we   <= w_sel ? m1_we   : m0_we;
                r_ram_addr <= w_sel ? m1_addr : m0_addr;
                r_ram_din  <= w_sel ? m1_din  : m0_din;
                r_grant    <= w_sel ? 2'b10   : 2'b01;
                r_cnt      <= '0;
            end

            if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_finish || w_abort) begin
                r_ram_cs <= 1'b0;
                r_last   <= r_grant[1];
                r_ack    <= r_grant;
                if (w_abort) begin
                    r_err <= r_grant;
                end
                // A write leaves the winner's dout untouched; an aborted read
                // returns zero rather than whatever is on ram_dout.
                if (!r_ram_we) begin
                    if (r_grant[0]) begin
                        r_m0_dout <= w_abort ? '0 : ram_dout;
                    end
                    if (r_grant[1]) begin
                        r_m1_dout <= w_abort ? '0 : ram_dout;
                    end
                end
            end

            if (r_state == ST_DONE) begin
                r_grant <= '0;
            end
        end
    end

    assign m0_dout  = r_m0_dout;
    assign m1_dout  = r_m1_dout;
    assign m0_ack   = r_ack[0];
    assign m1_ack   = r_ack[1];
    assign m0_err   = r_err[0];
    assign m1_err   = r_err[1];
    assign m0_stall = m0_cs & ~r_ack[0];
    assign m1_stall = m1_cs & ~r_ack[1];
    assign ram_cs   = r_ram_cs;
    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;
    assign grant    = r_grant;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_ram_arbiter
//
// Directed bench for data_ram_arbiter. A small behavioural RAM acks four cycles
// after ram_cs rises. Expected completions are pushed to a scoreboard queue as
// requests are driven and popped as mX_ack pulses are observed.
// -----------------------------------------------------------------------------
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_cs = 1'b0, m1_cs = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_din = '0,  m1_din = '0;
    logic [31:0] m0_dout, m1_dout;
    logic        m0_ack, m1_ack, m0_err, m1_err, m0_stall, m1_stall;
    logic        ram_cs, ram_we;
    logic [31:0] ram_addr, ram_din;
    logic [31:0] ram_dout;
    logic        ram_ack;
    logic [1:0]  grant;
    logic        busy;

    always #5 clk = ~clk;

    data_ram_arbiter #(.TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_cs    (m0_cs),
        .m1_cs    (m1_cs),
        .m0_we    (m0_we),
        .m1_we    (m1_we),
        .m0_addr  (m0_addr),
        .m1_addr  (m1_addr),
        .m0_din   (m0_din),
        .m1_din   (m1_din),
        .m0_dout  (m0_dout),
        .m1_dout  (m1_dout),
        .m0_ack   (m0_ack),
        .m1_ack   (m1_ack),
        .m0_err   (m0_err),
        .m1_err   (m1_err),
        .m0_stall (m0_stall),
        .m1_stall (m1_stall),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .ram_ack  (ram_ack),
        .grant    (grant),
        .busy     (busy)
    );

    // ------------------------------------------------------------------ RAM model
    logic        ram_ack_en = 1'b1;
    logic        stray_ack  = 1'b0;
    logic        model_ack  = 1'b0;
    logic [31:0] mem [0:255];
    bit          model_init;
    int          rcnt;

    assign ram_ack = model_ack | stray_ack;

    always @(posedge clk) begin
        if (!model_init) begin
            mem[4]     <= 32'hDEAD_BEEF;   // byte address 0x10
            mem[16]    <= 32'hA5A5_0040;   // byte address 0x40
            model_init <= 1'b1;
        end
        if (ram_cs && ram_ack_en && !model_ack) begin
            if (rcnt == 3) begin
                model_ack <= 1'b1;
                rcnt      <= 0;
                if (ram_we) mem[ram_addr[9:2]] <= ram_din;
                else        ram_dout <= mem[ram_addr[9:2]];
            end else begin
                rcnt <= rcnt + 1;
            end
        end else begin
            model_ack <= 1'b0;
            if (!ram_cs) rcnt <= 0;
        end
    end

    // ------------------------------------------------------------------ checking
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          m;
        logic [31:0] dout;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] dout_mdl [2] = '{32'h0, 32'h0};

    // Queue the expected completion of a transfer; dout_mdl tracks what each
    // master's dout must read after that completion.
    task automatic expect_xfer(input int m, input logic we, input logic [31:0] rd,
                               input logic err, input int cyc);
        exp_t e;
        if (we)       e.dout = dout_mdl[m];
        else if (err) e.dout = 32'h0;
        else          e.dout = rd;
        dout_mdl[m] = e.dout;
        e.m   = m;
        e.err = err;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic start_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] din);
        if (m == 0) begin
            m0_cs = 1'b1; m0_we = we; m0_addr = addr; m0_din = din;
        end else begin
            m1_cs = 1'b1; m1_we = we; m1_addr = addr; m1_din = din;
        end
    endtask

    task automatic drop_req(input int m);
        if (m == 0) m0_cs = 1'b0;
        else        m1_cs = 1'b0;
    endtask

    function automatic logic ack_of(input int m);
        return (m == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 0) ? m0_err : m1_err;
    endfunction

    function automatic logic [31:0] dout_of(input int m);
        return (m == 0) ? m0_dout : m1_dout;
    endfunction

    // Observe n completions. Cycle 0 is the cycle in which the requests were
    // driven. With pipe_grant nonzero, the first transfer is also checked
    // cycle by cycle against the nominal 1..6 BUSY/DONE timeline.
    task automatic run(input int n, input int budget, input bit hold,
                       input logic [1:0] pipe_grant);
        int got = 0;
        for (int t = 0; t < budget && got < n; t++) begin
            @(negedge clk);
            if (pipe_grant != 2'b00 && got == 0 && t >= 1 && t <= 6) begin
                check("pipe_grant", 32'(grant), 32'(pipe_grant));
                check("pipe_busy",  32'(busy),  32'd1);
                check("pipe_ram_cs", 32'(ram_cs), (t <= 5) ? 32'd1 : 32'd0);
                if (t <= 5) begin
                    check("pipe_stall0", 32'(m0_stall), 32'(m0_cs));
                    check("pipe_stall1", 32'(m1_stall), 32'(m1_cs));
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (ack_of(m)) begin
                    exp_t e;
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 32'(m), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("ack_master", 32'(m),         32'(e.m));
                        check("ack_cycle",  32'(t),         32'(e.cyc));
                        check("ack_dout",   dout_of(m),     e.dout);
                        check("ack_err",    32'(err_of(m)), 32'(e.err));
                        check("ack_grant",  32'(grant),     32'(2'b01 << m));
                    end
                    got++;
                    if (!hold) drop_req(m);
                end
            end
        end
        check("acks_in_budget", 32'(got), 32'(n));
        if (hold) begin
            drop_req(0);
            drop_req(1);
        end
    endtask

    // ------------------------------------------------------------------ stimulus
    initial begin
        // Reset state; stall follows cs even in reset.
        m0_cs = 1'b1;
        #1;
        check("rst_stall0", 32'(m0_stall), 32'd1);
        check("rst_stall1", 32'(m1_stall), 32'd0);
        check("rst_ram_cs", 32'(ram_cs),   32'd0);
        check("rst_ram_we", 32'(ram_we),   32'd0);
        check("rst_ram_addr", ram_addr,    32'd0);
        check("rst_ram_din",  ram_din,     32'd0);
        check("rst_grant",  32'(grant),    32'd0);
        check("rst_busy",   32'(busy),     32'd0);
        check("rst_acks",   32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        check("rst_m0_dout", m0_dout,      32'd0);
        check("rst_m1_dout", m1_dout,      32'd0);
        m0_cs = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Simultaneous requests after reset: m0 first, m1 at cycle 7.
        start_cycle();
        expect_xfer(0, 1'b0, 32'hDEAD_BEEF, 1'b0, 6);
        expect_xfer(1, 1'b0, 32'hA5A5_0040, 1'b0, 13);
        drive(0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b0, 32'h40, 32'h0);
        run(2, 30, 1'b0, 2'b01);

        // Both held: grants alternate m0, m1, m0, m1.
        start_cycle();
        expect_xfer(0, 1'b0, 32'hDEAD_BEEF, 1'b0, 6);
        expect_xfer(1, 1'b0, 32'hA5A5_0040, 1'b0, 13);
        expect_xfer(0, 1'b0, 32'hDEAD_BEEF, 1'b0, 20);
        expect_xfer(1, 1'b0, 32'hA5A5_0040, 1'b0, 27);
        drive(0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b0, 32'h40, 32'h0);
        run(4, 50, 1'b1, 2'b01);

        // Single read by m0.
        start_cycle();
        expect_xfer(0, 1'b0, 32'hDEAD_BEEF, 1'b0, 6);
        drive(0, 1'b0, 32'h10, 32'h0);
        run(1, 20, 1'b0, 2'b01);

        // m1 writes 0x40 (its dout unchanged), m0 reads it back.
        start_cycle();
        expect_xfer(1, 1'b1, 32'h0, 1'b0, 6);
        drive(1, 1'b1, 32'h40, 32'h1234_5678);
        run(1, 20, 1'b0, 2'b10);
        start_cycle();
        expect_xfer(0, 1'b0, 32'h1234_5678, 1'b0, 6);
        drive(0, 1'b0, 32'h40, 32'h0);
        run(1, 20, 1'b0, 2'b01);

        // Timeout: RAM never acks; ack+err 17 cycles after the request cycle.
        ram_ack_en = 1'b0;
        start_cycle();
        expect_xfer(0, 1'b0, 32'h0, 1'b1, 17);
        drive(0, 1'b0, 32'h10, 32'h0);
        run(1, 40, 1'b0, 2'b00);
        ram_ack_en = 1'b1;
        start_cycle();
        expect_xfer(1, 1'b0, 32'h1234_5678, 1'b0, 6);
        drive(1, 1'b0, 32'h40, 32'h0);
        run(1, 20, 1'b0, 2'b10);

        // Reset in cycle 3 of a BUSY: everything drops at once, no ack.
        start_cycle();
        drive(0, 1'b0, 32'h10, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_ram_cs", 32'(ram_cs), 32'd0);
        check("mid_rst_grant",  32'(grant),  32'd0);
        check("mid_rst_busy",   32'(busy),   32'd0);
        m0_cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
        end
        check("mid_rst_m0_dout", m0_dout, 32'd0);
        check("mid_rst_m1_dout", m1_dout, 32'd0);
        dout_mdl[0] = 32'h0;
        dout_mdl[1] = 32'h0;
        rst = 1'b1;
        start_cycle();
        expect_xfer(0, 1'b0, 32'hDEAD_BEEF, 1'b0, 6);
        drive(0, 1'b0, 32'h10, 32'h0);
        run(1, 20, 1'b0, 2'b01);

        // Stray ram_ack in IDLE is ignored.
        start_cycle();
        stray_ack = 1'b1;
        start_cycle();
        stray_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
            check("stray_idle",   32'({busy, grant, ram_cs}), 32'd0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
